// File: rtl/sys_bus_bridge_if.sv
// sys_bus_bridge_if
//   Bundles the CPU data-port handshake and the broadcast slave bus of
//   sys_bus_bridge.
//   modport slave  : the bridge (takes CPU requests, drives the slave bus)
//   modport master : the CPU / environment side (issues requests, returns
//                    slave read data)
//   Signals:
//     cpu_req, cpu_addr[31:0], cpu_wdata[31:0], cpu_byteen[3:0], intr_req
//     cpu_rdata[31:0], cpu_ready, cpu_err
//     slv_addr[31:0], slv_wdata[31:0], slv_byteen[3:0], slv_we[NSLV-1:0]
//     slv_rdata[NSLV*32-1:0], m_int_addr[31:0], m_int_byteen[3:0]
interface sys_bus_bridge_if #(
  parameter int unsigned NSLV = 3
);
  logic                 cpu_req;
  logic [31:0]          cpu_addr;
  logic [31:0]          cpu_wdata;
  logic [3:0]           cpu_byteen;
  logic                 intr_req;
  logic [31:0]          cpu_rdata;
  logic                 cpu_ready;
  logic                 cpu_err;
  logic [31:0]          slv_addr;
  logic [31:0]          slv_wdata;
  logic [3:0]           slv_byteen;
  logic [NSLV-1:0]      slv_we;
  logic [NSLV*32-1:0]   slv_rdata;
  logic [31:0]          m_int_addr;
  logic [3:0]           m_int_byteen;

  modport slave (
    input  cpu_req, cpu_addr, cpu_wdata, cpu_byteen, intr_req, slv_rdata,
    output cpu_rdata, cpu_ready, cpu_err, slv_addr, slv_wdata, slv_byteen,
           slv_we, m_int_addr, m_int_byteen
  );

  modport master (
    output cpu_req, cpu_addr, cpu_wdata, cpu_byteen, intr_req, slv_rdata,
    input  cpu_rdata, cpu_ready, cpu_err, slv_addr, slv_wdata, slv_byteen,
           slv_we, m_int_addr, m_int_byteen
  );
endinterface

// File: rtl/sys_bus_bridge.sv
// sys_bus_bridge
//   CPU-to-peripheral bridge. Decodes the CPU data-port address against NSLV
//   base/mask windows (lowest index wins), runs each access through an
//   IDLE -> ACCESS (WAITS[sel] extra cycles) -> DONE wait-state FSM, issues a
//   one-hot write strobe in the last ACCESS cycle, registers read data and
//   pulses cpu_ready for one cycle in DONE. Also drives the interrupt-generator
//   probe (m_int_addr / m_int_byteen).
//   Ports:
//     clk    : system clock, rising edge
//     reset  : synchronous, active-high; aborts any access in flight
//     bus    : sys_bus_bridge_if.slave (CPU handshake + broadcast slave bus)
//   Optional feature macro: BRIDGE_ERR_EN
//     defined   : unmapped access raises cpu_err with cpu_ready, read data
//                 becomes 32'hDEAD_BEEF
//     undefined : cpu_err tied low, unmapped reads return 0
module sys_bus_bridge #(
  parameter int unsigned          NSLV     = 3,
  parameter logic [NSLV*32-1:0]   BASE     = {32'h0000_7F20, 32'h0000_7F00, 32'h0000_0000},
  parameter logic [NSLV*32-1:0]   MASK     = {32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_C000},
  parameter logic [NSLV*4-1:0]    WAITS    = {4'h1, 4'h3, 4'h0},
  parameter logic [31:0]          INT_BASE = 32'h0000_7F20,
  parameter logic [31:0]          INT_MASK = 32'hFFFF_FFFC
) (
  input  logic              clk,
  input  logic              reset,
  sys_bus_bridge_if.slave   bus
);

  localparam int unsigned SELW = (NSLV > 1) ? $clog2(NSLV) : 1;

`ifdef BRIDGE_ERR_EN
  localparam logic [31:0] UNMAPPED_RDATA = 32'hDEAD_BEEF;
`else
  localparam logic [31:0] UNMAPPED_RDATA = 32'h0000_0000;
`endif

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state, state_nx;
  logic [3:0]        cnt;
  logic [SELW-1:0]   sel;
  logic              mapped;
  logic              wr;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        byteen_q;
  logic [31:0]       rdata_q;

  logic [SELW-1:0]   dec_sel;
  logic              dec_hit;
  logic              strobe;
  logic              int_hit;

  // Priority decode of the live CPU address: first hit in index order wins.
  always_comb begin
    dec_hit = 1'b0;
    dec_sel = '0;
    for (int unsigned i = 0; i < NSLV; i++) begin
      if (!dec_hit && ((bus.cpu_addr & MASK[32*i +: 32]) == BASE[32*i +: 32])) begin
        dec_hit = 1'b1;
        dec_sel = SELW'(i);
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.cpu_req) state_nx = ACCESS;
      ACCESS:  if (cnt == '0)   state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Access latches, wait counter and registered read data
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      sel      <= '0;
      mapped   <= 1'b0;
      wr       <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      byteen_q <= '0;
      rdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cpu_req) begin
            addr_q   <= bus.cpu_addr;
            wdata_q  <= bus.cpu_wdata;
            byteen_q <= bus.cpu_byteen;
            sel      <= dec_sel;
            mapped   <= dec_hit;
            wr       <= (|bus.cpu_byteen) & ~bus.intr_req;
            cnt      <= dec_hit ? WAITS[4*dec_sel +: 4] : 4'h0;
          end
        end
        ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - 4'h1;
          end else if (byteen_q == '0) begin
            // Any write, including one suppressed by intr_req, keeps the old read data.
            rdata_q <= mapped ? bus.slv_rdata[32*sel +: 32] : UNMAPPED_RDATA;
          end
        end
        default: ;
      endcase
    end
  end

  assign strobe  = (state == ACCESS) && (cnt == '0);
  assign int_hit = (addr_q & INT_MASK) == INT_BASE;

  // Output logic
  always_comb begin
    bus.slv_we       = '0;
    bus.m_int_byteen = '0;
    bus.cpu_ready    = 1'b0;
    bus.cpu_err      = 1'b0;
    if (strobe) begin
      if (mapped && wr) bus.slv_we[sel] = 1'b1;
      if (wr && int_hit) bus.m_int_byteen = byteen_q;
    end
    if (state == DONE) begin
      bus.cpu_ready = 1'b1;
`ifdef BRIDGE_ERR_EN
      bus.cpu_err   = ~mapped;
`endif
    end
  end

  assign bus.cpu_rdata  = rdata_q;
  assign bus.slv_addr   = addr_q;
  assign bus.slv_wdata  = wdata_q;
  assign bus.slv_byteen = byteen_q;
  assign bus.m_int_addr = addr_q;

endmodule

// File: tb/tb_sys_bus_bridge.sv
// tb_sys_bus_bridge
//   Directed scoreboard bench for sys_bus_bridge. The driver pushes the
//   expected strobe and completion of each access into queues; a monitor
//   sampling on the falling edge pops and compares whenever the DUT shows a
//   strobe (slv_we / m_int_byteen) or a cpu_ready pulse.
//   Cycle numbering: the request edge's cycle is 1 less than the first
//   ACCESS cycle, so ready is expected at WAITS+2 and a strobe at WAITS+1.
module tb_sys_bus_bridge;

  localparam int unsigned NSLV = 3;

`ifdef BRIDGE_ERR_EN
  localparam logic [31:0] UNM_RD  = 32'hDEAD_BEEF;
  localparam logic        UNM_ERR = 1'b1;
`else
  localparam logic [31:0] UNM_RD  = 32'h0000_0000;
  localparam logic        UNM_ERR = 1'b0;
`endif

  typedef struct {
    int          edge_n;
    int          rel;
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  typedef struct {
    int          edge_n;
    int          rel;
    logic [2:0]  we;
    logic [3:0]  ib;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } strb_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  resp_t resp_q[$];
  strb_t strb_q[$];

  sys_bus_bridge_if #(.NSLV(NSLV)) bus ();

  sys_bus_bridge #(
    .NSLV     (NSLV),
    .BASE     ({32'h0000_7F20, 32'h0000_7F00, 32'h0000_0000}),
    .MASK     ({32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_C000}),
    .WAITS    ({4'h1, 4'h3, 4'h0}),
    .INT_BASE (32'h0000_7F20),
    .INT_MASK (32'hFFFF_FFFC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Monitor: compare whatever the DUT presents against the queued expectation.
  always @(negedge clk) begin
    if (bus.cpu_ready) begin
      if (resp_q.size() == 0) begin
        chk("ready_without_request", 32'(bus.cpu_ready), 32'h0);
      end else begin
        resp_t r;
        r = resp_q.pop_front();
        chk("ready_cycle", 32'(cyc - r.edge_n + 1), 32'(r.rel));
        chk("cpu_rdata",   bus.cpu_rdata,           r.rdata);
        chk("cpu_err",     32'(bus.cpu_err),        32'(r.err));
      end
    end
    if ((bus.slv_we != '0) || (bus.m_int_byteen != '0)) begin
      if (strb_q.size() == 0) begin
        chk("unexpected_slv_we",       32'(bus.slv_we),       32'h0);
        chk("unexpected_m_int_byteen", 32'(bus.m_int_byteen), 32'h0);
      end else begin
        strb_t s;
        s = strb_q.pop_front();
        chk("strobe_cycle", 32'(cyc - s.edge_n + 1), 32'(s.rel));
        chk("slv_we",       32'(bus.slv_we),         32'(s.we));
        chk("m_int_byteen", 32'(bus.m_int_byteen),   32'(s.ib));
        chk("slv_addr",     bus.slv_addr,            s.addr);
        chk("m_int_addr",   bus.m_int_addr,          s.addr);
        chk("slv_wdata",    bus.slv_wdata,           s.wdata);
        chk("slv_byteen",   32'(bus.slv_byteen),     32'(s.be));
      end
    end
  end

  task automatic check_cleared(input string tag);
    chk({tag, "_cpu_rdata"},    bus.cpu_rdata,              32'h0);
    chk({tag, "_cpu_ready"},    32'(bus.cpu_ready),         32'h0);
    chk({tag, "_cpu_err"},      32'(bus.cpu_err),           32'h0);
    chk({tag, "_slv_we"},       32'(bus.slv_we),            32'h0);
    chk({tag, "_slv_addr"},     bus.slv_addr,               32'h0);
    chk({tag, "_slv_wdata"},    bus.slv_wdata,              32'h0);
    chk({tag, "_slv_byteen"},   32'(bus.slv_byteen),        32'h0);
    chk({tag, "_m_int_byteen"}, 32'(bus.m_int_byteen),      32'h0);
  endtask

  // One access: request for one edge, queue expectations, then idle long
  // enough for completion plus the turnaround cycle.
  task automatic xfer(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                      input logic ir, input logic [2:0] we_e, input logic [3:0] ib_e,
                      input int srel, input int rrel, input logic [31:0] rd_e, input logic err_e);
    resp_t r;
    strb_t s;
    @(negedge clk);
    bus.cpu_req    = 1'b1;
    bus.cpu_addr   = a;
    bus.cpu_wdata  = wd;
    bus.cpu_byteen = be;
    bus.intr_req   = ir;
    if ((we_e != '0) || (ib_e != '0)) begin
      s.edge_n = cyc + 1; s.rel = srel; s.we = we_e; s.ib = ib_e;
      s.addr = a; s.wdata = wd; s.be = be;
      strb_q.push_back(s);
    end
    r.edge_n = cyc + 1; r.rel = rrel; r.rdata = rd_e; r.err = err_e;
    resp_q.push_back(r);
    @(negedge clk);
    // Keep the request raised through the access: it must be ignored outside IDLE.
    bus.intr_req   = 1'b0;
    bus.cpu_wdata  = 32'hFFFF_FFFF;
    repeat (rrel - 1) @(negedge clk);
    bus.cpu_req    = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    reset          = 1'b1;
    bus.cpu_req    = 1'b0;
    bus.cpu_addr   = '0;
    bus.cpu_wdata  = '0;
    bus.cpu_byteen = '0;
    bus.intr_req   = 1'b0;
    bus.slv_rdata  = {32'h0BAD_F00D, 32'hCAFE_0001, 32'h1234_5678};
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_cleared("reset");
    reset = 1'b0;

    //   addr          wdata         be     ir    we      ib     srel rrel rdata          err
    xfer(32'h0000_0010, 32'h0,        4'h0, 1'b0, 3'b000, 4'h0,  0, 2, 32'h1234_5678, 1'b0);
    xfer(32'h0000_7F04, 32'hA5A5_A5A5, 4'hF, 1'b0, 3'b010, 4'h0,  4, 5, 32'h1234_5678, 1'b0);
    xfer(32'h0000_7F04, 32'hA5A5_A5A5, 4'hF, 1'b1, 3'b000, 4'h0,  0, 5, 32'h1234_5678, 1'b0);
    xfer(32'h0000_7F20, 32'h1122_3344, 4'h3, 1'b0, 3'b100, 4'h3,  2, 3, 32'h1234_5678, 1'b0);
    xfer(32'h9000_0000, 32'h0,        4'h0, 1'b0, 3'b000, 4'h0,  0, 2, UNM_RD,        UNM_ERR);
    xfer(32'h0000_7F08, 32'h0,        4'h0, 1'b0, 3'b000, 4'h0,  0, 5, 32'hCAFE_0001, 1'b0);
    xfer(32'h0000_7F24, 32'h0,        4'h0, 1'b1, 3'b000, 4'h0,  0, 3, 32'h0BAD_F00D, 1'b0);
    xfer(32'h0000_0100, 32'h5555_0000, 4'h8, 1'b0, 3'b001, 4'h0,  1, 2, 32'h0BAD_F00D, 1'b0);
    xfer(32'h9000_0004, 32'h7777_7777, 4'hF, 1'b0, 3'b000, 4'h0,  0, 2, 32'h0BAD_F00D, UNM_ERR);

    // Reset in the middle of a WAITS=3 write: nothing may follow from it.
    @(negedge clk);
    bus.cpu_req    = 1'b1;
    bus.cpu_addr   = 32'h0000_7F04;
    bus.cpu_wdata  = 32'hA5A5_A5A5;
    bus.cpu_byteen = 4'hF;
    @(negedge clk);
    bus.cpu_req    = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_cleared("abort");
    reset = 1'b0;
    repeat (6) @(negedge clk);

    xfer(32'h0000_0010, 32'h0,        4'h0, 1'b0, 3'b000, 4'h0,  0, 2, 32'h1234_5678, 1'b0);
    repeat (3) @(negedge clk);

    chk("resp_queue_drained",   32'(resp_q.size()), 32'h0);
    chk("strobe_queue_drained", 32'(strb_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
